// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control sequencer: opcodes, FSM
// state encoding, instruction classes and the packed control-strobe word.
`timescale 1ns/1ps
package cpu_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
    localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
    localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
    localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
    localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
    localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
    localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
    localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
    localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
    localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
    localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
    localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
    localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
    localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
    localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
    localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
    localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
    localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
    localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
    localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_T5,
        S_T6,
        S_T7,
        S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_ALU3,
        C_IMM,
        C_UNARY,
        C_MULDIV,
        C_LD,
        C_ST,
        C_NOP,
        C_HALT
    } iclass_t;

    // One bit per datapath strobe; cleared as a whole to guarantee no stray strobes.
    typedef struct packed {
        logic pc_out;
        logic zhigh_out;
        logic zlow_out;
        logic mdr_out;
        logic hi_out;
        logic lo_out;
        logic c_out;
        logic ba_out;
        logic pc_in;
        logic ir_in;
        logic mar_in;
        logic mdr_in;
        logic y_in;
        logic z_in;
        logic hi_in;
        logic lo_in;
        logic inc_pc;
        logic gra;
        logic grb;
        logic grc;
        logic r_in;
        logic r_out;
        logic read;
        logic write;
    } ctrl_t;

    // States in which the sequencer stalls on the memory handshake.
    function automatic logic is_mem_wait(input state_t s, input iclass_t c);
        return (s == S_T1) || ((s == S_T6) && (c == C_LD)) || ((s == S_T7) && (c == C_ST));
    endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational opcode classifier; unknown opcodes behave as nop.
`timescale 1ns/1ps
module ctrl_decode
    import cpu_pkg::*;
(
    input  logic [OP_W-1:0] opcode,
    output iclass_t         iclass
);

    // Map each opcode onto the step sequence it needs.
    always_comb begin
        iclass = C_NOP;
        case (opcode)
            OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHR,
            OP_SHRA, OP_SHL, OP_ROR, OP_ROL:         iclass = C_ALU3;
            OP_ADDI, OP_ANDI, OP_ORI:                iclass = C_IMM;
            OP_NEG, OP_NOT:                          iclass = C_UNARY;
            OP_MUL, OP_DIV:                          iclass = C_MULDIV;
            OP_LD:                                   iclass = C_LD;
            OP_ST:                                   iclass = C_ST;
            OP_HALT:                                 iclass = C_HALT;
            default:                                 iclass = C_NOP;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Hardwired Moore control sequencer for the 32-bit bus datapath: one control
// step per clock through fetch (T0-T2) and class-specific execute (T3-T7).
// Optional single-step mode: define CTRL_STEP_EN to add the Step input, which
// holds the FSM in T0 with strobes off until Step is seen on a clock edge.
`timescale 1ns/1ps
module control_unit
    import cpu_pkg::*;
#(
    parameter int IR_W        = 32,
    parameter int OPCODE_W    = 5,
    parameter int MEM_TIMEOUT = 0
) (
    input  logic                Clock,
    input  logic                Clear,
`ifdef CTRL_STEP_EN
    input  logic                Step,
`endif
    input  logic [IR_W-1:0]     IR,
    input  logic                MemReady,
    output logic                PCout,
    output logic                Zhighout,
    output logic                Zlowout,
    output logic                MDRout,
    output logic                HIout,
    output logic                LOout,
    output logic                Cout,
    output logic                BAout,
    output logic                PCin,
    output logic                IRin,
    output logic                MARin,
    output logic                MDRin,
    output logic                Yin,
    output logic                Zin,
    output logic                HIin,
    output logic                LOin,
    output logic                IncPC,
    output logic                Gra,
    output logic                Grb,
    output logic                Grc,
    output logic                Rin,
    output logic                Rout,
    output logic                Read,
    output logic                Write,
    output logic [OPCODE_W-1:0] alu_op,
    output logic                Run,
    output logic                MemErr
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

    state_t              state;
    state_t              state_next;
    iclass_t             iclass;
    ctrl_t               c;
    logic                entered;
    logic [CNT_W-1:0]    cnt;
    logic                mem_wait;
    logic                wait_expired;
    logic                timeout;
    logic                t0_go;
    logic [OPCODE_W-1:0] ir_op;
    logic                unused_ir_bits;

    assign ir_op          = IR[IR_W-1 -: OPCODE_W];
    assign unused_ir_bits = ^IR[IR_W-OPCODE_W-1:0];

    ctrl_decode u_decode (
        .opcode (IR[IR_W-1 -: OP_W]),
        .iclass (iclass)
    );

    assign mem_wait     = is_mem_wait(state, iclass);
    // A zero timeout means the handshake is waited on indefinitely.
    assign wait_expired = (MEM_TIMEOUT != 0) && (cnt == CNT_LAST);

`ifdef CTRL_STEP_EN
    logic go;

    // Arm one instruction per Step seen while parked in T0; disarm once it leaves T0.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            go <= 1'b0;
        else if (state != S_T0)
            go <= 1'b0;
        else if (Step)
            go <= 1'b1;
    end

    assign t0_go = go;
`else
    assign t0_go = 1'b1;
`endif

    // State register: Clear aborts any instruction immediately.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            state <= S_RST;
        else
            state <= state_next;
    end

    // Entry flag (for the one-shot PCin) and handshake wait counter, both restart on a state change.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            entered <= 1'b0;
            cnt     <= '0;
        end else begin
            entered <= (state_next != state);
            if (state_next != state)
                cnt <= '0;
            else if (mem_wait)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Sticky memory-timeout flag, only cleared by Clear.
    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear)
            MemErr <= 1'b0;
        else if (timeout)
            MemErr <= 1'b1;
    end

    // Next state and per-step strobes; outputs depend only on state, instruction class and entry flag.
    always_comb begin
        state_next = state;
        c          = '0;
        alu_op     = '0;
        timeout    = 1'b0;
        case (state)
            S_RST: state_next = S_T0;
            S_T0: begin
                if (t0_go) begin
                    c.pc_out   = 1'b1;
                    c.mar_in   = 1'b1;
                    c.inc_pc   = 1'b1;
                    c.z_in     = 1'b1;
                    state_next = S_T1;
                end
            end
            S_T1: begin
                c.zlow_out = 1'b1;
                c.pc_in    = entered;
                c.read     = 1'b1;
                c.mdr_in   = 1'b1;
                if (MemReady) begin
                    state_next = S_T2;
                end else if (wait_expired) begin
                    state_next = S_HALT;
                    timeout    = 1'b1;
                end
            end
            S_T2: begin
                c.mdr_out  = 1'b1;
                c.ir_in    = 1'b1;
                state_next = S_T3;
            end
            S_T3: begin
                state_next = S_T4;
                case (iclass)
                    C_ALU3, C_IMM: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    C_UNARY: begin
                        c.grb  = 1'b1;
                        c.r_out = 1'b1;
                        c.z_in = 1'b1;
                        alu_op = ir_op;
                    end
                    C_MULDIV: begin
                        c.gra   = 1'b1;
                        c.r_out = 1'b1;
                        c.y_in  = 1'b1;
                    end
                    C_LD, C_ST: begin
                        c.grb    = 1'b1;
                        c.ba_out = 1'b1;
                        c.y_in   = 1'b1;
                    end
                    C_HALT:  state_next = S_HALT;
                    default: state_next = S_T0;
                endcase
            end
            S_T4: begin
                state_next = S_T5;
                case (iclass)
                    C_ALU3: begin
                        c.grc   = 1'b1;
                        c.r_out = 1'b1;
                        c.z_in  = 1'b1;
                        alu_op  = ir_op;
                    end
                    C_IMM: begin
                        c.c_out = 1'b1;
                        c.z_in  = 1'b1;
                        alu_op  = ir_op;
                    end
                    C_UNARY: begin
                        c.zlow_out = 1'b1;
                        c.gra      = 1'b1;
                        c.r_in     = 1'b1;
                        state_next = S_T0;
                    end
                    C_MULDIV: begin
                        c.grb   = 1'b1;
                        c.r_out = 1'b1;
                        c.z_in  = 1'b1;
                        alu_op  = ir_op;
                    end
                    C_LD, C_ST: begin
                        c.c_out = 1'b1;
                        c.z_in  = 1'b1;
                        alu_op  = OPCODE_W'(OP_ADD);
                    end
                    default: state_next = S_T0;
                endcase
            end
            S_T5: begin
                state_next = S_T6;
                case (iclass)
                    C_ALU3, C_IMM: begin
                        c.zlow_out = 1'b1;
                        c.gra      = 1'b1;
                        c.r_in     = 1'b1;
                        state_next = S_T0;
                    end
                    C_MULDIV: begin
                        c.zlow_out = 1'b1;
                        c.lo_in    = 1'b1;
                    end
                    C_LD, C_ST: begin
                        c.zlow_out = 1'b1;
                        c.mar_in   = 1'b1;
                    end
                    default: state_next = S_T0;
                endcase
            end
            S_T6: begin
                state_next = S_T0;
                case (iclass)
                    C_MULDIV: begin
                        c.zhigh_out = 1'b1;
                        c.hi_in     = 1'b1;
                    end
                    C_LD: begin
                        c.read   = 1'b1;
                        c.mdr_in = 1'b1;
                        if (MemReady) begin
                            state_next = S_T7;
                        end else if (wait_expired) begin
                            state_next = S_HALT;
                            timeout    = 1'b1;
                        end else begin
                            state_next = S_T6;
                        end
                    end
                    C_ST: begin
                        // Read low steers the bus value into MDR rather than memory data.
                        c.gra      = 1'b1;
                        c.r_out    = 1'b1;
                        c.mdr_in   = 1'b1;
                        state_next = S_T7;
                    end
                    default: state_next = S_T0;
                endcase
            end
            S_T7: begin
                state_next = S_T0;
                case (iclass)
                    C_LD: begin
                        c.mdr_out = 1'b1;
                        c.gra     = 1'b1;
                        c.r_in    = 1'b1;
                    end
                    C_ST: begin
                        c.write = 1'b1;
                        if (MemReady) begin
                            state_next = S_T0;
                        end else if (wait_expired) begin
                            state_next = S_HALT;
                            timeout    = 1'b1;
                        end else begin
                            state_next = S_T7;
                        end
                    end
                    default: state_next = S_T0;
                endcase
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

    assign Run      = (state != S_RST) && (state != S_HALT);

    assign PCout    = c.pc_out;
    assign Zhighout = c.zhigh_out;
    assign Zlowout  = c.zlow_out;
    assign MDRout   = c.mdr_out;
    assign HIout    = c.hi_out;
    assign LOout    = c.lo_out;
    assign Cout     = c.c_out;
    assign BAout    = c.ba_out;
    assign PCin     = c.pc_in;
    assign IRin     = c.ir_in;
    assign MARin    = c.mar_in;
    assign MDRin    = c.mdr_in;
    assign Yin      = c.y_in;
    assign Zin      = c.z_in;
    assign HIin     = c.hi_in;
    assign LOin     = c.lo_in;
    assign IncPC    = c.inc_pc;
    assign Gra      = c.gra;
    assign Grb      = c.grb;
    assign Grc      = c.grc;
    assign Rin      = c.r_in;
    assign Rout     = c.r_out;
    assign Read     = c.read;
    assign Write    = c.write;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit: each instruction pushes its expected
// per-cycle control word (plus the MemReady/IR values to drive) into a queue,
// which is popped and compared on every falling clock edge.
`timescale 1ns/1ps
module tb_control_unit;

    logic        Clock;
    logic        Clear;
`ifdef CTRL_STEP_EN
    logic        Step;
`endif
    logic [31:0] IR;
    logic        MemReady;
    logic        PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout;
    logic        PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC;
    logic        Gra, Grb, Grc, Rin, Rout, Read, Write;
    logic [4:0]  alu_op;
    logic        Run, MemErr;

    control_unit #(.IR_W(32), .OPCODE_W(5), .MEM_TIMEOUT(4)) dut (
        .Clock(Clock), .Clear(Clear),
`ifdef CTRL_STEP_EN
        .Step(Step),
`endif
        .IR(IR), .MemReady(MemReady),
        .PCout(PCout), .Zhighout(Zhighout), .Zlowout(Zlowout), .MDRout(MDRout),
        .HIout(HIout), .LOout(LOout), .Cout(Cout), .BAout(BAout),
        .PCin(PCin), .IRin(IRin), .MARin(MARin), .MDRin(MDRin), .Yin(Yin),
        .Zin(Zin), .HIin(HIin), .LOin(LOin), .IncPC(IncPC),
        .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout),
        .Read(Read), .Write(Write), .alu_op(alu_op), .Run(Run), .MemErr(MemErr)
    );

    // Strobe masks, PCout in the MSB down to Write in the LSB.
    localparam logic [23:0] PCO = 24'h1 << 23, ZHO = 24'h1 << 22, ZLO = 24'h1 << 21,
                            MDRO = 24'h1 << 20, CO = 24'h1 << 17, BAO = 24'h1 << 16,
                            PCI = 24'h1 << 15, IRI = 24'h1 << 14, MARI = 24'h1 << 13,
                            MDRI = 24'h1 << 12, YI = 24'h1 << 11, ZI = 24'h1 << 10,
                            HII = 24'h1 << 9, LOI = 24'h1 << 8, INC = 24'h1 << 7,
                            GRA = 24'h1 << 6, GRB = 24'h1 << 5, GRC = 24'h1 << 4,
                            RIN = 24'h1 << 3, ROUT = 24'h1 << 2, RD = 24'h1 << 1, WR = 24'h1;

    logic [30:0] obs;
    assign obs = {PCout, Zhighout, Zlowout, MDRout, HIout, LOout, Cout, BAout,
                  PCin, IRin, MARin, MDRin, Yin, Zin, HIin, LOin, IncPC,
                  Gra, Grb, Grc, Rin, Rout, Read, Write, alu_op, Run, MemErr};

    typedef struct {
        string       tag;
        logic [30:0] exp;
        logic        rdy;
        logic [31:0] ir;
        logic        stp;
    } ent_t;

    ent_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] cur_ir;
    string       cur_name;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [30:0] got, input logic [30:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b required %b", tag, got, exp);
        end
    endtask

    function automatic logic rnd();
        return logic'($urandom_range(0, 1));
    endfunction

    task automatic push_w(input string step, input logic [23:0] m, input logic [4:0] op,
                          input logic run, input logic err, input logic rdy, input logic stp);
        ent_t e;
        e.tag = {cur_name, " ", step};
        e.exp = {m, op, run, err};
        e.rdy = rdy;
        e.ir  = cur_ir;
        e.stp = stp;
        sb.push_back(e);
    endtask

    task automatic push(input string step, input logic [23:0] m, input logic [4:0] op, input logic rdy);
        push_w(step, m, op, 1'b1, 1'b0, rdy, 1'b0);
    endtask

    // A handshake step: w cycles with MemReady low, then one with it high.
    task automatic push_wait(input string step, input logic [23:0] m, input int w);
        push(step, m, 5'd0, w == 0);
        for (int i = 1; i <= w; i++)
            push({step, "w"}, m, 5'd0, i == w);
    endtask

    task automatic push_t0();
`ifdef CTRL_STEP_EN
        push_w("T0hold", 24'h0, 5'd0, 1'b1, 1'b0, rnd(), 1'b1);
`endif
        push("T0", PCO | MARI | INC | ZI, 5'd0, rnd());
    endtask

    task automatic push_instr(input string name, input logic [4:0] op, input int t1w, input int mw);
        cur_name = name;
        cur_ir   = {op, 27'($urandom)};
        push_t0();
        push("T1", ZLO | PCI | RD | MDRI, 5'd0, t1w == 0);
        for (int i = 1; i <= t1w; i++)
            push("T1w", ZLO | RD | MDRI, 5'd0, i == t1w);
        push("T2", MDRO | IRI, 5'd0, rnd());
        case (op)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011: begin
                push("T3", GRB | ROUT | YI, 5'd0, rnd());
                push("T4", GRC | ROUT | ZI, op, rnd());
                push("T5", ZLO | GRA | RIN, 5'd0, rnd());
            end
            5'b01100, 5'b01101, 5'b01110: begin
                push("T3", GRB | ROUT | YI, 5'd0, rnd());
                push("T4", CO | ZI, op, rnd());
                push("T5", ZLO | GRA | RIN, 5'd0, rnd());
            end
            5'b10001, 5'b10010: begin
                push("T3", GRB | ROUT | ZI, op, rnd());
                push("T4", ZLO | GRA | RIN, 5'd0, rnd());
            end
            5'b10000, 5'b01111: begin
                push("T3", GRA | ROUT | YI, 5'd0, rnd());
                push("T4", GRB | ROUT | ZI, op, rnd());
                push("T5", ZLO | LOI, 5'd0, rnd());
                push("T6", ZHO | HII, 5'd0, rnd());
            end
            5'b00000: begin
                push("T3", GRB | BAO | YI, 5'd0, rnd());
                push("T4", CO | ZI, 5'b00011, rnd());
                push("T5", ZLO | MARI, 5'd0, rnd());
                push_wait("T6", RD | MDRI, mw);
                push("T7", MDRO | GRA | RIN, 5'd0, rnd());
            end
            5'b00010: begin
                push("T3", GRB | BAO | YI, 5'd0, rnd());
                push("T4", CO | ZI, 5'b00011, rnd());
                push("T5", ZLO | MARI, 5'd0, rnd());
                push("T6", GRA | ROUT | MDRI, 5'd0, rnd());
                push_wait("T7", WR, mw);
            end
            5'b11011: begin
                push("T3", 24'h0, 5'd0, rnd());
                for (int i = 0; i < 10; i++)
                    push_w("HALT", 24'h0, 5'd0, 1'b0, 1'b0, rnd(), 1'b0);
            end
            default: push("T3", 24'h0, 5'd0, rnd());
        endcase
    endtask

    // Pop up to n expected cycles, comparing each one on the falling edge.
    task automatic consume(input int n);
        ent_t e;
        for (int i = 0; i < n && sb.size() > 0; i++) begin
            @(negedge Clock);
            e = sb.pop_front();
            check(e.tag, obs, e.exp);
            MemReady = e.rdy;
            IR       = e.ir;
`ifdef CTRL_STEP_EN
            Step     = e.stp;
`endif
        end
    endtask

    task automatic consume_all();
        consume(sb.size());
    endtask

    // Assert Clear on a falling edge, check it clears outputs at once, release a cycle later.
    task automatic pulse_clear(input string tag);
        Clear = 1'b1;
        sb.delete();
        #1;
        check({tag, " async"}, obs, 31'd0);
        @(negedge Clock);
        check({tag, " held"}, obs, 31'd0);
        Clear = 1'b0;
    endtask

    logic [4:0] op_tbl [12] = '{5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000, 5'b01001,
                                5'b01010, 5'b01011, 5'b01101, 5'b01110, 5'b10010, 5'b00001};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1);
    end

    initial begin
        Clear    = 1'b1;
        MemReady = 1'b0;
        IR       = '0;
`ifdef CTRL_STEP_EN
        Step     = 1'b0;
`endif
        repeat (2) @(negedge Clock);
        check("reset", obs, 31'd0);
        Clear = 1'b0;

        // Clear arriving in T4 of an add aborts it; the next instruction starts cleanly.
        push_instr("add_clr", 5'b00011, 0, 0);
        consume(5);
        pulse_clear("clear_mid_t4");

        push_instr("neg", 5'b10001, 0, 0);          consume_all();
        push_instr("add", 5'b00011, 0, 0);          consume_all();
        push_instr("addi", 5'b01100, 1, 0);         consume_all();
        push_instr("ld3", 5'b00000, 0, 3);          consume_all();
        push_instr("st2", 5'b00010, 2, 2);          consume_all();
        push_instr("ld0", 5'b00000, 0, 0);          consume_all();
        push_instr("div", 5'b01111, 0, 0);          consume_all();
        push_instr("nop", 5'b11010, 0, 0);          consume_all();
        push_instr("undef", 5'b11111, 0, 0);        consume_all();
        for (int i = 0; i < 12; i++) begin
            push_instr($sformatf("op%b", op_tbl[i]), op_tbl[i], int'($urandom_range(0, 2)), 0);
            consume_all();
        end

        push_instr("mul", 5'b10000, 0, 0);          consume_all();
        push_instr("halt", 5'b11011, 0, 0);         consume_all();
        pulse_clear("clear_halt");

        // Memory never answers in T1: four wait cycles, then sticky MemErr and HALT.
        cur_name = "tmo";
        cur_ir   = {5'b00011, 27'($urandom)};
        push_t0();
        push("T1", ZLO | PCI | RD | MDRI, 5'd0, 1'b0);
        for (int i = 0; i < 3; i++)
            push("T1w", ZLO | RD | MDRI, 5'd0, 1'b0);
        for (int i = 0; i < 6; i++)
            push_w("HALT", 24'h0, 5'd0, 1'b0, 1'b1, rnd(), 1'b0);
        consume_all();
        pulse_clear("clear_memerr");

        push_instr("add_after", 5'b00011, 0, 1);    consume_all();
        push_instr("st_last", 5'b00010, 0, 3);      consume_all();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
